// File: rtl/logic_sweep_ctrl.sv
// logic_sweep_ctrl: walks all eight a/b/c vectors through the function
// y = (a & b) | c, samples y at the end of each dwell window and reports
// the mismatch count, the first failing vector and an overall pass flag.
module logic_sweep_ctrl #(
  parameter int unsigned DWELL = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] fail_vec
);

  localparam int unsigned VEC_W = 3;
  localparam int unsigned DW_W  = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [VEC_W-1:0] VEC_LAST   = VEC_W'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [VEC_W-1:0] vec, vec_d;
  logic [DW_W-1:0]  dwell, dwell_d;
  logic [VEC_W-1:0] abc, abc_d;
  logic             busy_d, done_d, pass_d;
  logic [CNT_W-1:0] err_d;
  logic             fail_valid_d;
  logic [VEC_W-1:0] fail_vec_d;
  logic             expected_c;
  logic             mismatch_c;

  assign {a_o, b_o, c_o} = abc;

  // Golden value for the vector currently applied, and its comparison with y
  assign expected_c = (vec[2] & vec[1]) | vec[0];
  assign mismatch_c = y_i ^ expected_c;

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      dwell      <= '0;
      abc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state      <= state_d;
      vec        <= vec_d;
      dwell      <= dwell_d;
      abc        <= abc_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_count  <= err_d;
      fail_valid <= fail_valid_d;
      fail_vec   <= fail_vec_d;
    end
  end

  // Next-state and next-output logic; results hold unless updated
  always_comb begin
    state_d      = state;
    vec_d        = vec;
    dwell_d      = dwell;
    abc_d        = abc;
    busy_d       = busy;
    done_d       = 1'b0;
    pass_d       = pass;
    err_d        = err_count;
    fail_valid_d = fail_valid;
    fail_vec_d   = fail_vec;

    unique case (state)
      IDLE: begin
        abc_d = '0;
        if (start) begin
          state_d      = RUN;
          vec_d        = '0;
          dwell_d      = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end
      end

      RUN: begin
        if (dwell == DWELL_LAST) begin
          // Sample point: score this vector, then advance
          if (mismatch_c) begin
            err_d = err_count + CNT_W'(1);
            if (!fail_valid) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = vec;
            end
          end
          dwell_d = '0;
          if (vec == VEC_LAST) begin
            state_d = FIN;
            vec_d   = '0;
            abc_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_count == '0) && !mismatch_c;
          end else begin
            vec_d = vec + VEC_W'(1);
            abc_d = vec + VEC_W'(1);
          end
        end else begin
          dwell_d = dwell + DW_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
        abc_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        abc_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/logic_sweep_ctrl.md
Name: logic_sweep_ctrl

Overview:
- Sequencer that exercises the 3-input combinational function y = (a & b) | c, owning its a/b/c inputs and checking its y output.
- On a start pulse it walks all 8 input vectors in order, holds each for DWELL cycles, samples y and compares it with an internally computed expected value.
- Reports mismatch count, first failing vector and pass/fail.
- Sits between a bench or top-level test harness and the combinational logic instance.

Parameters:
- DWELL, 2, cycles each vector is held before y_i is sampled; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep; accepted only in IDLE.
- y_i  in  1  output of the function under test.
- a_o  out  1  drives input a (vector bit 2).
- b_o  out  1  drives input b (vector bit 1).
- c_o  out  1  drives input c (vector bit 0).
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  1 when the last completed sweep had zero mismatches.
- err_count  out  4  mismatches in the last or current sweep (0..8).
- fail_valid  out  1  1 once any mismatch has been seen in the current or last sweep.
- fail_vec  out  3  vector index of the first mismatch; valid when fail_valid=1.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE.
  - a_o/b_o/c_o=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0.
  - Vector counter and dwell counter are cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - a_o/b_o/c_o=0; result outputs hold their last values.
  - start=1 -> RUN next edge. At that edge: vec=0, dwell counter=0, err_count=0, fail_valid=0, fail_vec=0, pass=0, busy=1.
- RUN:
  - {a_o,b_o,c_o}=vec, registered and stable for exactly DWELL cycles per vector.
  - Dwell counter runs 0..DWELL-1.
  - On the cycle where the dwell counter equals DWELL-1, y_i is sampled at the clock edge and compared with expected = (vec[2] & vec[1]) | vec[0].
  - On mismatch: err_count increments (4 bits, no overflow possible, max 8). If fail_valid=0, fail_vec<=vec and fail_valid<=1.
  - After the sample, vec increments and the dwell counter resets.
  - After vec=7 is sampled -> FIN.
- Expected sequence, vec 0..7: 0,1,0,1,0,1,1,1.
- FIN (lasts exactly one cycle):
  - done=1, busy=0, pass=(err_count==0), counting the vec=7 result. a_o/b_o/c_o=0.
  - Then -> IDLE.
- Latency: start sampled at edge E0 -> busy high from E0 through E0+8*DWELL -> done high for the cycle after edge E0+8*DWELL.
- start while in RUN or FIN: ignored, no restart, no effect on counters.
- start held high continuously: a new sweep begins on the first IDLE cycle after FIN.
- y_i is sampled only on dwell-final cycles; values on other cycles are ignored.
- rst asserted mid-sweep: immediate return to reset values; no done pulse; partial results are discarded.
- pass stays 0 from start until FIN; it never shows 1 during RUN.

Test Plan:
1. DWELL=2, y_i driven by a correct (a&b)|c model, single start pulse -> busy high 16 cycles, one done pulse; pass=1, err_count=0, fail_valid=0; observed vector order 000..111, each held 2 cycles.
2. y_i stuck at 0 -> err_count=5 (vectors 1,3,5,6,7), fail_vec=1, fail_valid=1, pass=0.
3. y_i modelled as a|b|c -> err_count=2 (vectors 2 and 4), fail_vec=2, pass=0; then rerun with the correct model -> err_count=0, fail_valid=0, pass=1.
4. Pulse start again at RUN cycle 5 and during FIN -> no restart; exactly one done pulse, 16 cycles after the original start; results match scenario 1.
5. Assert rst asynchronously (mid-cycle) at vec=4 -> a_o/b_o/c_o, busy, err_count, fail_valid and pass drop to 0 immediately; no done pulse; the next start runs a full 8-vector sweep.
6. DWELL=1 with the correct model -> busy for 8 cycles, done on the 9th cycle after the start edge, and a new vector every cycle.
